// File: rtl/mult8_seq_2bits_ctrl.sv
// -----------------------------------------------------------------------------
// mult8_seq_2bits_ctrl
//
// Computes an 8x8 unsigned product by driving one external combinational 4x4
// multiplier core over four consecutive cycles. It accumulates the four
// shifted partial products into a 16-bit result.
//
// Operands enter through a valid/ready handshake. The product leaves through
// a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   A/B are valid
//   in_ready   operands can be accepted (IDLE only)
//   A, B       8-bit unsigned operands
//   out_valid  P holds a completed product
//   out_ready  consumer accepts P
//   P          registered 16-bit product
//   mul_a      A nibble driven to the external 4x4 core
//   mul_b      B nibble driven to the external 4x4 core
//   mul_p      8-bit product returned by the core
//   busy       high in every state other than IDLE
//   op_count   number of delivered products (wraps)
// -----------------------------------------------------------------------------
module mult8_seq_2bits_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] P,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LL   = 3'd1,
    S_LH   = 3'd2,
    S_HL   = 3'd3,
    S_HH   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  a_reg, b_reg;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] p_reg;
  logic [15:0] count_reg;
  logic [15:0] term;

  // Nibble views of the captured operands: index 0 is the low nibble, 1 the high.
  logic [3:0] a_nib [2];
  logic [3:0] b_nib [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*4 +: 4];
      assign b_nib[gi] = b_reg[gi*4 +: 4];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (in_valid)  state_next = S_LL;
      S_LL:                   state_next = S_LH;
      S_LH:                   state_next = S_HL;
      S_HL:                   state_next = S_HH;
      S_HH:                   state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // Output / core-drive logic. The core is fed only from the captured operands.
  // Each partial product is zero-extended and aligned to its nibble weight.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mul_a     = 4'h0;
    mul_b     = 4'h0;
    term      = 16'h0000;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_LL: begin
        mul_a = a_nib[0];
        mul_b = b_nib[0];
        term  = {8'h00, mul_p};
      end
      S_LH: begin
        mul_a = a_nib[0];
        mul_b = b_nib[1];
        term  = {4'h0, mul_p, 4'h0};
      end
      S_HL: begin
        mul_a = a_nib[1];
        mul_b = b_nib[0];
        term  = {4'h0, mul_p, 4'h0};
      end
      S_HH: begin
        mul_a = a_nib[1];
        mul_b = b_nib[1];
        term  = {mul_p, 8'h00};
      end
      S_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // The sum never exceeds 0xFE01, so 16 bits cannot overflow.
  assign acc_next = acc_reg + term;

  // Datapath: operand capture, accumulation, result and delivery counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
      acc_reg   <= 16'h0000;
      p_reg     <= 16'h0000;
      count_reg <= 16'h0000;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_reg   <= A;
            b_reg   <= B;
            acc_reg <= 16'h0000;
          end
        end
        S_LL, S_LH, S_HL: acc_reg <= acc_next;
        S_HH: begin
          acc_reg <= acc_next;
          p_reg   <= acc_next;
        end
        S_DONE: begin
          if (out_ready) count_reg <= count_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign P        = p_reg;
  assign op_count = count_reg;

endmodule

// File: tb/tb_mult8_seq_2bits_ctrl.sv
module tb_mult8_seq_2bits_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A, B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic        busy;
  logic [15:0] op_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_exp = 16'h0000;

  always #5 clk = ~clk;

  // External 4x4 core
  assign mul_p = mul_a * mul_b;

  mult8_seq_2bits_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete transaction. Inputs are driven and outputs sampled on negedges.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                        input int hold, input bit pre_ready, input bit interfere);
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    ea = '{a[3:0], a[3:0], a[7:4], a[7:4]};
    eb = '{b[3:0], b[7:4], b[3:0], b[7:4]};

    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = pre_ready;
    check("in_ready_idle", in_ready, 1);
    @(negedge clk);                       // after accept edge: LL
    in_valid = 1'b0; A = ~a; B = ~b;      // operands in flight must not change
    for (int s = 0; s < 4; s++) begin
      if (s > 0) @(negedge clk);
      if (interfere && s == 1) begin in_valid = 1'b1; A = 8'hFF; B = 8'hFF; end
      if (interfere && s == 3) in_valid = 1'b0;
      check("mul_a_step", mul_a, ea[s]);
      check("mul_b_step", mul_b, eb[s]);
      check("out_valid_step", out_valid, 0);
      check("in_ready_step", in_ready, 0);
      check("busy_step", busy, 1);
      check("op_count_step", op_count, cnt_exp);
    end
    @(negedge clk);                       // DONE, 4 edges after accept
    check("out_valid_done", out_valid, 1);
    check("P_done", P, exp_p);
    check("in_ready_done", in_ready, 0);
    check("busy_done", busy, 1);
    check("mul_a_done", mul_a, 0);
    check("mul_b_done", mul_b, 0);
    check("op_count_done", op_count, cnt_exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("out_valid_hold", out_valid, 1);
      check("P_hold", P, exp_p);
      check("in_ready_hold", in_ready, 0);
      check("op_count_hold", op_count, cnt_exp);
    end
    out_ready = 1'b1;
    @(negedge clk);                       // back in IDLE
    cnt_exp = cnt_exp + 16'd1;
    check("out_valid_after", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("busy_after", busy, 0);
    check("op_count_after", op_count, cnt_exp);
    check("P_after", P, exp_p);
    out_ready = 1'b0;
    $display("op A=%02h B=%02h P=%04h exp=%04h op_count=%0d", a, b, P, exp_p, op_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = 8'h00; B = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_P", P, 0);
    check("rst_op_count", op_count, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    rst_n = 1'b1;

    run_op(8'h00, 8'h00, 16'h0000, 0, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b1, 1'b0);
    run_op(8'hA5, 8'h3C, 16'h26AC, 0, 1'b0, 1'b0);
    run_op(8'h12, 8'h34, 16'h03A8, 10, 1'b0, 1'b0);
    run_op(8'h0F, 8'hF0, 16'h0E10, 0, 1'b0, 1'b1);

    // Reset asserted during HL discards the operation
    @(negedge clk);
    A = 8'h12; B = 8'h34; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;      // LL
    @(negedge clk);                       // LH
    @(negedge clk);                       // HL
    check("mul_a_hl", mul_a, 4'h1);
    check("mul_b_hl", mul_b, 4'h4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_P", P, 0);
    check("midrst_op_count", op_count, 0);
    check("midrst_mul_a", mul_a, 0);
    rst_n = 1'b1;
    cnt_exp = 16'h0000;
    $display("reset mid-operation P=%04h op_count=%0d", P, op_count);

    run_op(8'h07, 8'h09, 16'h003F, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
